// File: rtl/demultiplexer_3.sv
// One-to-three stream demultiplexer with a one-entry holding register per channel.
// Optional drop counter for in_sel==3 words is enabled by defining DEMUX_ERR_CNT_EN.
module demultiplexer_3 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [7:0]       err_cnt
);

  logic             accept;
  logic [WIDTH-1:0] data_w [3];

  // A channel can take a word when empty or when its current word drains on this edge.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = !out_valid[0] || out_ready[0];
      2'd1:    in_ready = !out_valid[1] || out_ready[1];
      2'd2:    in_ready = !out_valid[2] || out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             wr;

      assign wr = accept && (in_sel == 2'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (wr) begin
          valid_reg <= 1'b1;
          data_reg  <= in_data;
        end else if (valid_reg && out_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign out_valid[gi] = valid_reg;
      assign data_w[gi]    = data_reg;
    end
  endgenerate

  assign out_data0 = data_w[0];
  assign out_data1 = data_w[1];
  assign out_data2 = data_w[2];

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Saturating count of words dropped for the invalid destination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'h00;
    end else if (accept && (in_sel == 2'd3) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'h01;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_demultiplexer_3.sv
// Self-checking bench for demultiplexer_3: vector table plus per-channel scoreboard queues.
// Expected drop count follows DEMUX_ERR_CNT_EN.
module tb_demultiplexer_3;

  localparam int WIDTH = 16;
`ifdef DEMUX_ERR_CNT_EN
  localparam logic [7:0] ERR_AFTER_300 = 8'hFF;
  localparam bit         ERR_EN        = 1'b1;
`else
  localparam logic [7:0] ERR_AFTER_300 = 8'h00;
  localparam bit         ERR_EN        = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [7:0]       err_cnt;

  demultiplexer_3 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] od [3];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;

  int total = 0;
  int bad   = 0;

  // Reference model of the channel state and a per-channel scoreboard.
  logic [2:0]       m_valid = '0;
  logic [WIDTH-1:0] m_data [3] = '{default: '0};
  logic [7:0]       m_err = 8'h00;
  logic [WIDTH-1:0] sbq [3][$];
  bit               rdy_chk = 1'b0;

  typedef struct {
    logic             v;
    logic [1:0]       sel;
    logic [WIDTH-1:0] d;
    logic [2:0]       ordy;
    logic             exp_rdy;
    logic [2:0]       exp_valid;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                       input logic [2:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
  endtask

  // One clock: check in_ready and drains before the edge, state after it.
  task automatic tick(output logic rdy_seen);
    logic       exp_rdy;
    logic       acc;
    logic [7:0] exp_err;
    logic [WIDTH-1:0] got;
    @(negedge clk);
    rdy_seen = in_ready;
    exp_rdy  = (in_sel == 2'd3) ? 1'b1 : (!m_valid[in_sel] || out_ready[in_sel]);
    if (rdy_chk) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = in_valid && exp_rdy;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i] && out_ready[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("drain_ch%0d_unexpected", i), 32'd1, 32'd0);
          end else begin
            got = sbq[i].pop_front();
            chk($sformatf("drain_ch%0d_data", i), {16'd0, od[i]}, {16'd0, got});
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (acc && in_sel == 2'(i)) begin
          m_valid[i] = 1'b1;
          m_data[i]  = in_data;
          sbq[i].push_back(in_data);
        end else if (m_valid[i] && out_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (acc && in_sel == 2'd3 && m_err != 8'hFF) m_err = m_err + 8'h01;
    end else begin
      m_valid = '0;
      m_err   = 8'h00;
      for (int i = 0; i < 3; i++) begin
        m_data[i] = '0;
        sbq[i].delete();
      end
    end
    @(posedge clk);
    #1;
    exp_err = ERR_EN ? m_err : 8'h00;
    chk("out_valid", {29'd0, out_valid}, {29'd0, m_valid});
    chk("out_data0", {16'd0, out_data0}, {16'd0, m_data[0]});
    chk("out_data1", {16'd0, out_data1}, {16'd0, m_data[1]});
    chk("out_data2", {16'd0, out_data2}, {16'd0, m_data[2]});
    chk("err_cnt",   {24'd0, err_cnt},   {24'd0, exp_err});
  endtask

  initial begin
    logic r;

    vecs[0] = '{1'b1, 2'd1, 16'hA5A5, 3'b000, 1'b1, 3'b010};
    vecs[1] = '{1'b1, 2'd1, 16'h1111, 3'b000, 1'b0, 3'b010};
    vecs[2] = '{1'b1, 2'd2, 16'h2222, 3'b000, 1'b1, 3'b110};
    vecs[3] = '{1'b1, 2'd0, 16'h0001, 3'b001, 1'b1, 3'b111};
    vecs[4] = '{1'b1, 2'd0, 16'h0002, 3'b001, 1'b1, 3'b111};
    vecs[5] = '{1'b1, 2'd0, 16'h0003, 3'b001, 1'b1, 3'b111};
    vecs[6] = '{1'b1, 2'd0, 16'h0004, 3'b001, 1'b1, 3'b111};
    vecs[7] = '{1'b0, 2'd1, 16'hDEAD, 3'b011, 1'b1, 3'b100};
    vecs[8] = '{1'b0, 2'd3, 16'hBEEF, 3'b100, 1'b1, 3'b000};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, '0, 3'b000);
    tick(r);
    rdy_chk = 1'b1;
    tick(r);
    $display("reset: out_valid=%b err_cnt=%h", out_valid, err_cnt);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].v, vecs[k].sel, vecs[k].d, vecs[k].ordy);
      tick(r);
      chk($sformatf("vec%0d_in_ready", k), {31'd0, r}, {31'd0, vecs[k].exp_rdy});
      chk($sformatf("vec%0d_out_valid", k), {29'd0, out_valid}, {29'd0, vecs[k].exp_valid});
      $display("vec %0d: v=%b sel=%0d d=%h ordy=%b -> rdy=%b out_valid=%b d0=%h d1=%h d2=%h",
               k, vecs[k].v, vecs[k].sel, vecs[k].d, vecs[k].ordy, r, out_valid,
               out_data0, out_data1, out_data2);
    end

    // Invalid destination: park a word in channel 1, then 300 drops.
    drive(1'b1, 2'd1, 16'h0BEE, 3'b000);
    tick(r);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 2'd3, 16'($urandom), 3'b000);
      tick(r);
      $display("drop %0d: rdy=%b out_valid=%b err_cnt=%h", k, r, out_valid, err_cnt);
    end
    chk("drop_err_cnt_final", {24'd0, err_cnt}, {24'd0, ERR_AFTER_300});
    chk("drop_out_valid", {29'd0, out_valid}, 32'd2);
    chk("drop_out_data1", {16'd0, out_data1}, 32'h0BEE);

    // Reset while all channels hold words, with a transfer offered on the reset edge.
    drive(1'b1, 2'd0, 16'h00C0, 3'b000);
    tick(r);
    drive(1'b1, 2'd2, 16'h00C2, 3'b000);
    tick(r);
    chk("pre_rst_out_valid", {29'd0, out_valid}, 32'd7);
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 16'hFFFF, 3'b000);
    tick(r);
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_out_data0", {16'd0, out_data0}, 32'd0);
    chk("rst_out_data1", {16'd0, out_data1}, 32'd0);
    chk("rst_out_data2", {16'd0, out_data2}, 32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    $display("mid reset: out_valid=%b d0=%h d1=%h d2=%h err_cnt=%h",
             out_valid, out_data0, out_data1, out_data2, err_cnt);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 16'h1234, 3'b000);
    tick(r);
    chk("post_rst_out_valid", {29'd0, out_valid}, 32'd4);
    chk("post_rst_out_data2", {16'd0, out_data2}, 32'h1234);
    drive(1'b0, 2'd0, '0, 3'b100);
    tick(r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
